// File: rtl/alu_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_unit
//  Purpose  : Registered EX-stage ALU with an iterative radix-2 multiply /
//             divide engine and architectural HI/LO registers.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_md_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [4:0] OP_AND  = 5'h00, OP_OR   = 5'h01, OP_ADD  = 5'h02,
                          OP_ADDU = 5'h03, OP_SUBU = 5'h04, OP_XOR  = 5'h05,
                          OP_SUB  = 5'h06, OP_SLT  = 5'h07, OP_SLL  = 5'h08,
                          OP_SRL  = 5'h09, OP_ANDI = 5'h0A, OP_ORI  = 5'h0B,
                          OP_NOR  = 5'h0C, OP_SRA  = 5'h0D, OP_SLTU = 5'h0E,
                          OP_MULT = 5'h10, OP_DIV  = 5'h12,
                          OP_MFHI = 5'h14, OP_MFLO = 5'h15, OP_MTHI = 5'h16,
                          OP_MTLO = 5'h17;

   localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   logic [1:0]       state, state_nx;
   logic [SHW-1:0]   count;
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
   logic             neg_lo, neg_hi;

   logic             accept, is_md, is_sgn, busy, last;
   logic [WIDTH-1:0] mag_a, mag_b, sum, diff, alu_res;
   logic             alu_ovf;

   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;
   logic [2*WIDTH-1:0] mul_full, mul_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;

   assign accept = in_valid && in_ready;
   assign is_md  = (op[4:2] == 3'b100);
   assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
   assign mag_a  = (is_sgn && src_a[WIDTH-1]) ? -src_a : src_a;
   assign mag_b  = (is_sgn && src_b[WIDTH-1]) ? -src_b : src_b;
   assign busy   = (state == S_MUL) || (state == S_DIV);
   assign last   = (count == LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state: a mul/div can be taken from IDLE or the DONE cycle
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept && is_md) state_nx = op[1] ? S_DIV : S_MUL;
            else                 state_nx = S_IDLE;
         end
         S_MUL, S_DIV: if (last) state_nx = S_DONE;
         default:      state_nx = S_IDLE;
      endcase
   end

   // FSM outputs: stall upstream only while the engine iterates
   always_comb begin
      in_ready = !((state == S_MUL) || (state == S_DIV));
   end

   // Single-cycle ALU results and signed overflow
   always_comb begin
      sum     = src_a + src_b;
      diff    = src_a - src_b;
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         OP_AND, OP_ANDI: alu_res = src_a & src_b;
         OP_OR, OP_ORI:   alu_res = src_a | src_b;
         OP_XOR:          alu_res = src_a ^ src_b;
         OP_NOR:          alu_res = ~(src_a | src_b);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_ADDU:         alu_res = sum;
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_SUBU:         alu_res = diff;
         OP_SLT:          alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         OP_SLTU:         alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
         OP_SLL:          alu_res = src_b << shamt;
         OP_SRL:          alu_res = src_b >> shamt;
         OP_SRA:          alu_res = $signed(src_b) >>> shamt;
         OP_MFHI:         alu_res = hi;
         OP_MFLO:         alu_res = lo;
         default:         alu_res = '0;
      endcase
   end

   // One radix-2 step of shift-add multiply / restoring divide, plus sign fix
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      mul_hi_nx = mul_sum[WIDTH:1];
      mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      div_hi_nx = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      div_lo_nx = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
      mul_full  = {mul_hi_nx, mul_lo_nx};
      mul_fix   = neg_lo ? -mul_full : mul_full;
      q_fix     = neg_lo ? -div_lo_nx : div_lo_nx;
      r_fix     = neg_hi ? -div_hi_nx : div_hi_nx;
   end

   // Datapath: operand load, iteration, HI/LO and registered result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         opnd      <= '0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         out_valid <= 1'b0;
         if (accept) begin
            if (is_md) begin
               count  <= '0;
               acc_hi <= '0;
               acc_lo <= op[1] ? mag_a : mag_b;
               opnd   <= op[1] ? mag_b : mag_a;
               // Divide by zero keeps the quotient at all ones; remainder
               // sign fix then restores the original dividend.
               neg_lo <= is_sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]) &&
                         !(op[1] && (src_b == '0));
               neg_hi <= is_sgn && (op[1] ? src_a[WIDTH-1] : (src_a[WIDTH-1] ^ src_b[WIDTH-1]));
            end else begin
               result    <= alu_res;
               ovf       <= alu_ovf;
               out_valid <= 1'b1;
               if (op == OP_MTHI) hi <= src_a;
               if (op == OP_MTLO) lo <= src_a;
            end
         end
         if (busy) begin
            count <= count + SHW'(1);
            if (state == S_MUL) begin
               acc_hi <= mul_hi_nx;
               acc_lo <= mul_lo_nx;
            end else begin
               acc_hi <= div_hi_nx;
               acc_lo <= div_lo_nx;
            end
            if (last) begin
               out_valid <= 1'b1;
               ovf       <= 1'b0;
               if (state == S_MUL) begin
                  hi     <= mul_fix[2*WIDTH-1:WIDTH];
                  lo     <= mul_fix[WIDTH-1:0];
                  result <= mul_fix[WIDTH-1:0];
               end else begin
                  hi     <= r_fix;
                  lo     <= q_fix;
                  result <= q_fix;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_md_unit
//  Purpose  : Self-checking bench for alu_md_unit with an arithmetic
//             reference model of the ALU and HI/LO behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_md_unit;
   localparam int W  = 32;
   localparam int SW = 5;

   logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
   logic          in_ready, out_valid, ovf;
   logic [4:0]    op = '0;
   logic [W-1:0]  src_a = '0, src_b = '0, result, hi, lo;
   logic [SW-1:0] shamt = '0;

   int            checks = 0, failures = 0;
   logic [W-1:0]  m_hi = '0, m_lo = '0;

   always #5 clk = ~clk;

   alu_md_unit #(.WIDTH(W), .SHW(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .src_a(src_a), .src_b(src_b), .shamt(shamt),
      .out_valid(out_valid), .result(result), .ovf(ovf), .hi(hi), .lo(lo));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void ref_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh, output logic [31:0] r, output logic v);
      longint s;
      r = '0;
      v = 1'b0;
      case (o)
         5'h00, 5'h0A: r = a & b;
         5'h01, 5'h0B: r = a | b;
         5'h05:        r = a ^ b;
         5'h0C:        r = ~(a | b);
         5'h02: begin
            s = longint'($signed(a)) + longint'($signed(b));
            r = s[31:0];
            v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
         end
         5'h03:        r = a + b;
         5'h06: begin
            s = longint'($signed(a)) - longint'($signed(b));
            r = s[31:0];
            v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
         end
         5'h04:        r = a - b;
         5'h07:        r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'h0E:        r = (a < b) ? 32'd1 : 32'd0;
         5'h08:        r = b << sh;
         5'h09:        r = b >> sh;
         5'h0D:        r = $signed(b) >>> sh;
         5'h14:        r = m_hi;
         5'h15:        r = m_lo;
         default:      r = '0;
      endcase
   endfunction

   function automatic void ref_md(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
      longint          p;
      longint unsigned pu;
      int              qa, qb;
      h = '0;
      l = '0;
      case (o)
         5'h10: begin
            p = longint'($signed(a)) * longint'($signed(b));
            h = p[63:32];
            l = p[31:0];
         end
         5'h11: begin
            pu = {32'b0, a} * {32'b0, b};
            h  = pu[63:32];
            l  = pu[31:0];
         end
         5'h12: begin
            if (b == 0) begin
               l = 32'hFFFFFFFF; h = a;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               l = 32'h80000000; h = 32'h0;
            end else begin
               qa = $signed(a);
               qb = $signed(b);
               l  = 32'(qa / qb);
               h  = 32'(qa % qb);
            end
         end
         default: begin
            if (b == 0) begin
               l = 32'hFFFFFFFF; h = a;
            end else begin
               l = a / b; h = a % b;
            end
         end
      endcase
   endfunction

   function automatic logic [31:0] rnd();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic single(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input string tag);
      logic [31:0] er;
      logic        ev;
      @(negedge clk);
      ref_alu(o, a, b, sh, er, ev);
      chk({tag, ".ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; op = o; src_a = a; src_b = b; shamt = sh;
      @(negedge clk);
      in_valid = 1'b0;
      if (o == 5'h16) m_hi = a;
      if (o == 5'h17) m_lo = a;
      chk({tag, ".valid"},  32'(out_valid), 32'd1);
      chk({tag, ".result"}, result, er);
      chk({tag, ".ovf"},    32'(ovf), 32'(ev));
      chk({tag, ".hi"},     hi, m_hi);
      chk({tag, ".lo"},     lo, m_lo);
   endtask

   task automatic muldiv(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int          cyc, lowc;
      logic [31:0] eh, el;
      ref_md(o, a, b, eh, el);
      @(negedge clk);
      in_valid = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      in_valid = 1'b0;
      cyc  = 1;
      lowc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin
         if (in_ready === 1'b0) lowc++;
         @(negedge clk);
         cyc++;
      end
      m_hi = eh;
      m_lo = el;
      chk({tag, ".latency"}, 32'(cyc), 32'(W + 1));
      chk({tag, ".stall"},   32'(lowc), 32'(W));
      chk({tag, ".result"},  result, el);
      chk({tag, ".hi"},      hi, eh);
      chk({tag, ".lo"},      lo, el);
      chk({tag, ".ovf"},     32'(ovf), 32'd0);
      @(negedge clk);
      chk({tag, ".pulse"},   32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [4:0]  sops [22] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h14,
                                 5'h15, 5'h16, 5'h17, 5'h0F, 5'h1F, 5'h18};
      logic [4:0]  st_op [4] = '{5'h00, 5'h0D, 5'h0E, 5'h07};
      logic [31:0] st_a  [4] = '{32'hF0F0, 32'h0, 32'h1, 32'hFFFFFFFF};
      logic [31:0] st_b  [4] = '{32'h0FF0, 32'h80000000, 32'hFFFFFFFF, 32'h1};
      logic [4:0]  st_sh [4] = '{5'd0, 5'd4, 5'd0, 5'd0};
      logic [31:0] st_ex [4] = '{32'h00F0, 32'hF8000000, 32'h1, 32'h1};
      logic [31:0] eh, el;
      int          cyc, hits;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.ready", 32'(in_ready), 32'd1);
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.result", result, 32'd0);
      chk("rst.ovf", 32'(ovf), 32'd0);
      chk("rst.hi", hi, 32'd0);
      chk("rst.lo", lo, 32'd0);
      rst_n = 1'b1;

      single(5'h02, 32'h7FFFFFFF, 32'h1, 5'd0, "add_ovf");
      single(5'h03, 32'h7FFFFFFF, 32'h1, 5'd0, "addu");
      single(5'h06, 32'h80000000, 32'h1, 5'd0, "sub_ovf");

      // Back-to-back stream, one accept per cycle
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; op = st_op[i]; src_a = st_a[i]; src_b = st_b[i]; shamt = st_sh[i];
         @(negedge clk);
         chk("stream.valid", 32'(out_valid), 32'd1);
         chk("stream.result", result, st_ex[i]);
      end
      in_valid = 1'b0;

      muldiv(5'h10, 32'hFFFFFFFE, 32'd3, "mult");
      muldiv(5'h11, 32'hFFFFFFFE, 32'd3, "multu");
      muldiv(5'h12, 32'hFFFFFFF9, 32'd2, "div");
      muldiv(5'h13, 32'd7, 32'd0, "divu0");
      muldiv(5'h12, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      muldiv(5'h12, 32'hFFFFFFF9, 32'd0, "div0_neg");

      single(5'h16, 32'h1234, 32'h0, 5'd0, "mthi");
      single(5'h17, 32'hABCD, 32'h0, 5'd0, "mtlo");
      single(5'h15, 32'h0, 32'h0, 5'd0, "mflo");
      single(5'h14, 32'h0, 32'h0, 5'd0, "mfhi");

      // in_valid held through a divide: the waiting mflo must not slip in early
      ref_md(5'h13, 32'd100, 32'd7, eh, el);
      @(negedge clk);
      in_valid = 1'b1; op = 5'h13; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
      op = 5'h15; src_a = 32'h5555; src_b = 32'h0;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      m_hi = eh; m_lo = el;
      chk("hold.latency", 32'(cyc), 32'(W + 1));
      chk("hold.div", result, el);
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold.next_valid", 32'(out_valid), 32'd1);
      chk("hold.mflo", result, m_lo);
      @(negedge clk);
      chk("hold.idle", 32'(out_valid), 32'd0);

      // Randomised mix against the reference model
      for (int i = 0; i < 60; i++) begin
         if ((i % 6) == 5)
            muldiv(5'(5'h10 + $urandom_range(0, 3)), rnd(), rnd(), "rnd_md");
         else
            single(sops[$urandom_range(0, 21)], rnd(), rnd(), 5'($urandom_range(0, 31)), "rnd_alu");
      end

      // Reset in the middle of a multiply
      single(5'h16, 32'hDEAD, 32'h0, 5'd0, "pre_rst_mthi");
      @(negedge clk);
      in_valid = 1'b1; op = 5'h10; src_a = 32'h12345; src_b = 32'h6789;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      m_hi = '0; m_lo = '0;
      chk("midrst.hi", hi, 32'd0);
      chk("midrst.lo", lo, 32'd0);
      chk("midrst.valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) hits++;
      end
      chk("midrst.no_valid", 32'(hits), 32'd0);
      chk("midrst.ready", 32'(in_ready), 32'd1);
      chk("midrst.hi_after", hi, 32'd0);
      single(5'h02, 32'd5, 32'hFFFFFFFE, 5'd0, "post_rst_add");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
